// File: rtl/riscv_types.sv
// -----------------------------------------------------------------------------
// riscv_types
// Shared type package for the atomic (AMO) datapath.
//   amo_t             : AMO ALU operation encoding
//   amo_sched_state_t : ownership state of the AMO port scheduler
//   idx_width()       : width of an index into an N-entry vector (min 1 bit)
// -----------------------------------------------------------------------------
package riscv_types;

    typedef enum logic [3:0] {
        AMOSWAP = 4'd0,
        AMOADD  = 4'd1,
        AMOXOR  = 4'd2,
        AMOAND  = 4'd3,
        AMOOR   = 4'd4,
        AMOMIN  = 4'd5,
        AMOMAX  = 4'd6,
        AMOMINU = 4'd7,
        AMOMAXU = 4'd8
    } amo_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } amo_sched_state_t;

    // A single requester still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/amo_rr_picker.sv
// -----------------------------------------------------------------------------
// amo_rr_picker
// Combinational round-robin picker for a shared port. The search starts at
// ptr+1 (mod NUM_UNITS) and returns the first requesting index.
// Ports:
//   req       in  NUM_UNITS  request vector
//   ptr       in  IDX_W      index of the previous winner
//   win_idx   out IDX_W      winning index (0 when nothing requests)
//   win_valid out 1          at least one request present
// -----------------------------------------------------------------------------
module amo_rr_picker
    import riscv_types::*;
#(
    parameter int NUM_UNITS = 3,
    parameter int IDX_W     = idx_width(NUM_UNITS)
) (
    input  logic [NUM_UNITS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     win_idx,
    output logic                 win_valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

    logic [IDX_W-1:0] cand_s;

    // Walk every index once, wrapping explicitly so non-power-of-two counts work.
    always_comb begin
        win_idx   = IDX_W'(0);
        win_valid = 1'b0;
        cand_s    = (ptr == LAST_IDX) ? IDX_W'(0) : ptr + IDX_W'(1);
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!win_valid && req[cand_s]) begin
                win_valid = 1'b1;
                win_idx   = cand_s;
            end else begin
                win_valid = win_valid;
            end
            cand_s = (cand_s == LAST_IDX) ? IDX_W'(0) : cand_s + IDX_W'(1);
        end
    end

endmodule

// File: rtl/amo_sched.sv
// -----------------------------------------------------------------------------
// amo_sched
// Round-robin owner arbitration for one shared AMO ALU port. A granted unit
// owns the port for a full read-modify-write; exactly one ALU operation is
// forwarded per grant and its result is returned registered with a done pulse.
//
// Optional feature: define AMO_SCHED_TIMEOUT_EN to enable the ownership
// watchdog (TIMEOUT_CYCLES). Without it abort is constant 0.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   req               per-unit ownership request (level)
//   data_valid        owner's loaded word is on rs1 this cycle
//   release_req       owner gives up ownership
//   op, rs1, rs2      per-unit operation and operands
//   gnt               one-hot owner (registered)
//   done, result      one-cycle result pulse and registered ALU result
//   abort             one-cycle pulse when the watchdog revokes ownership
//   busy              scheduler not idle
//   amo_rmw_valid     ALU operation issued this cycle
//   amo_op, amo_rs1/2 operation/operands muxed from the owner
//   amo_rd            combinational ALU result
// -----------------------------------------------------------------------------
module amo_sched
    import riscv_types::*;
#(
    parameter int NUM_UNITS      = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_UNITS-1:0] req,
    input  logic [NUM_UNITS-1:0] data_valid,
    input  logic [NUM_UNITS-1:0] release_req,
    input  amo_t                 op  [NUM_UNITS],
    input  logic [31:0]          rs1 [NUM_UNITS],
    input  logic [31:0]          rs2 [NUM_UNITS],
    output logic [NUM_UNITS-1:0] gnt,
    output logic [NUM_UNITS-1:0] done,
    output logic [31:0]          result,
    output logic [NUM_UNITS-1:0] abort,
    output logic                 busy,
    output logic                 amo_rmw_valid,
    output amo_t                 amo_op,
    output logic [31:0]          amo_rs1,
    output logic [31:0]          amo_rs2,
    input  logic [31:0]          amo_rd
);

    localparam int               IDX_W   = idx_width(NUM_UNITS);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_UNITS - 1);

    amo_sched_state_t     state_d, state_q;
    logic [IDX_W-1:0]     owner_d, owner_q;
    logic [IDX_W-1:0]     ptr_d, ptr_q;
    logic [NUM_UNITS-1:0] gnt_d, gnt_q;
    logic [NUM_UNITS-1:0] done_d, done_q;
    logic [31:0]          result_d, result_q;

    logic [IDX_W-1:0]     pick_idx_s;
    logic                 pick_valid_s;
    logic                 own_valid_s;
    logic                 own_rel_s;
    logic                 timeout_s;
    logic                 issue_s;

    amo_rr_picker #(
        .NUM_UNITS (NUM_UNITS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req       (req),
        .ptr       (ptr_q),
        .win_idx   (pick_idx_s),
        .win_valid (pick_valid_s)
    );

    // Only the owner's handshakes matter; everyone else is ignored.
    assign own_valid_s = data_valid[owner_q];
    assign own_rel_s   = release_req[owner_q];

    // A release in the same cycle as the watchdog expiry keeps the op alive.
    assign issue_s = (state_q == GRANT) && own_valid_s && (own_rel_s || !timeout_s);

    assign amo_rmw_valid = issue_s;
    assign amo_op        = op[owner_q];
    assign amo_rs1       = rs1[owner_q];
    assign amo_rs2       = rs2[owner_q];

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign result = result_q;
    assign busy   = (state_q != IDLE);

`ifdef AMO_SCHED_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    logic [TMR_W-1:0]     timer_d, timer_q;
    logic [NUM_UNITS-1:0] abort_d, abort_q;

    assign timeout_s = (state_q != IDLE) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign abort     = abort_q;

    // Watchdog: held at 0 while idle so it starts from 0 on entering GRANT.
    always_comb begin
        abort_d = '0;
        if (state_q == IDLE) begin
            timer_d = TMR_W'(0);
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
        if (timeout_s && !own_rel_s) begin
            abort_d[owner_q] = 1'b1;
        end else begin
            abort_d = '0;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= TMR_W'(0);
            abort_q <= '0;
        end else begin
            timer_q <= timer_d;
            abort_q <= abort_d;
        end
    end
`else
    logic unused_timeout_cfg_s;

    assign timeout_s            = 1'b0;
    assign abort                = '0;
    assign unused_timeout_cfg_s = ^TIMEOUT_CYCLES;
`endif

    // Ownership FSM next-state, grant, result and done computation.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        result_d = result_q;

        if (issue_s) begin
            result_d        = amo_rd;
            done_d[owner_q] = 1'b1;
        end else begin
            result_d = result_q;
        end

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_valid_s) begin
                    state_d           = GRANT;
                    owner_d           = pick_idx_s;
                    ptr_d             = pick_idx_s;
                    gnt_d[pick_idx_s] = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (own_rel_s || timeout_s) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (issue_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = GRANT;
                end
            end
            HOLD: begin
                if (own_rel_s || timeout_s) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Ownership state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= IDX_W'(0);
            ptr_q    <= PTR_RST;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

endmodule

// File: doc/amo_sched.md
# amo_sched

Round-robin scheduler that shares one atomic read-modify-write datapath (the combinational AMO ALU port) among NUM_UNITS load/store requesters. It sits between the per-unit atomic sequencing logic and the AMO unit. It grants one requester exclusive ownership for a whole RMW: read, compute and write. It forwards exactly one ALU operation per grant and returns a registered result with a done pulse.

## Interface
- NUM_UNITS, 3, number of requesters (≥1)
- TIMEOUT_CYCLES, 64, ownership watchdog limit; used only with AMO_SCHED_TIMEOUT_EN (≥2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req  in  NUM_UNITS  requester wants ownership; level, held until granted
- data_valid  in  NUM_UNITS  owner's loaded memory word is on rs1 this cycle
- release  in  NUM_UNITS  owner gives up ownership (after its store, or to abort)
- op  in  NUM_UNITS×amo_t  per-unit AMO operation
- rs1  in  NUM_UNITS×32  per-unit memory operand
- rs2  in  NUM_UNITS×32  per-unit register operand
- gnt  out  NUM_UNITS  one-hot ownership, registered
- done  out  NUM_UNITS  one-cycle pulse, result valid for owner
- result  out  32  registered ALU result
- abort  out  NUM_UNITS  one-cycle pulse, ownership revoked by watchdog
- busy  out  1  state ≠ IDLE
- amo_rmw_valid  out  1  ALU operation issued this cycle
- amo_op  out  amo_t  operation to ALU, muxed from owner
- amo_rs1, amo_rs2  out  32  operands to ALU, muxed from owner
- amo_rd  in  32  ALU result, combinational, same cycle

## Operation
- States: IDLE, GRANT (owner waits for load data), HOLD (result delivered; owner is storing).
- IDLE: if |req, pick a winner round-robin, starting at index ptr+1 mod NUM_UNITS. Register gnt[w]. Go to GRANT. Set ptr ← w.
- GRANT: the amo_* outputs mux from owner w. amo_rmw_valid = data_valid[w]. On data_valid[w], capture result ← amo_rd, pulse done[w] next cycle, go to HOLD.
- GRANT with release[w] and no data_valid[w]: abort by requester. Go to IDLE with no done pulse.
- GRANT with data_valid[w] and release[w] in the same cycle: the op is issued, result is captured, done[w] pulses, and the next state is IDLE.
- HOLD: wait for release[w], then go to IDLE. data_valid in HOLD is ignored; one ALU op per grant.
- Inputs from non-owners are ignored: data_valid, release, op, rs1 and rs2.
- gnt drops in the cycle after release. Owners are separated by at least one cycle with no grant.
- amo_rmw_valid is 0 outside GRANT. amo_op and amo_rs* are don't-care when it is 0.
- Reset, asynchronous, at any time including mid-RMW: state IDLE, ptr = NUM_UNITS−1 so unit 0 is picked first, gnt/done/abort = 0, result = 0, busy = 0, timer = 0.
- ptr and owner index are $clog2(max(NUM_UNITS,2)) bits wide. Wrap-around is explicit modulo NUM_UNITS; non-power-of-two counts are legal.

## Timing
- req seen in IDLE at cycle 0 → gnt high at cycle 1.
- data_valid at cycle k (GRANT) → amo_rmw_valid at cycle k, combinational; done and result at k+1.
- release at cycle r → gnt low at r+1; IDLE at r+1; next gnt earliest r+2.
- Single requester streaming: one RMW per (3 + load latency + store latency) cycles minimum.

## Configuration
- AMO_SCHED_TIMEOUT_EN defined: a counter clears on entering GRANT and increments each cycle in GRANT or HOLD. When it reaches TIMEOUT_CYCLES−1 with no release that cycle:
  - go to IDLE;
  - pulse abort[w] next cycle;
  - no done pulse if still in GRANT.
- Release and timeout in the same cycle: release wins and there is no abort.
- AMO_SCHED_TIMEOUT_EN undefined: no counter; abort tied to 0; ownership is unbounded.

## Structure
- Shared package riscv_types: amo_sched_state_t enum (IDLE, GRANT, HOLD). amo_t is already defined there.
- One sub-module: amo_rr_picker. It is combinational. Inputs are the req vector and ptr; outputs are the winner index and a valid flag. It is reusable for other shared ports.
- The state register, owner index, ptr, result/done/abort registers and the optional timer stay in amo_sched.

## Test plan
- Single request, unit 1: req[1] at c0 → gnt=3'b010 at c1. data_valid[1] at c3 with op=AMOADD, rs1=5, rs2=7 → amo_rmw_valid at c3; result=12 and done[1] at c4. release at c6 → gnt=0 at c7.
- Fairness: req=3'b111 held, each owner releasing immediately after done. Grant order is 0,1,2,0 with a one-cycle gap between grants.
- Requester abort: in GRANT, release[2] without data_valid → IDLE next cycle. done and amo_rmw_valid never assert; result keeps its previous value.
- Same-cycle data_valid+release, op=AMOSWAP, rs2=0xDEADBEEF → result=0xDEADBEEF, done pulses, gnt drops, busy=0 the next cycle. Non-owner data_valid in any state has no effect.
- Watchdog (AMO_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=8): grant unit 0, never release → abort[0] pulses 8 cycles after gnt rises and gnt drops. With the macro off, gnt stays high for 1000 cycles.
- Reset asserted in HOLD → gnt, done, busy and result are 0 immediately. After deassertion with req=3'b110, unit 1 is granted first.
